sb_transaction_parser: RTL and testbench

//  Parametrised successor of the sideband transactions FSM. Parses the de-serialised SB symbol stream
//  (symbol valid strobe, one byte per strobe) into AT command/response and LT transactions.

---
 rtl/sb_transaction_parser.sv | 355 +++++++++++++++++++++++++++++++++++
 tb/tb_sb_transaction_parser.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_transaction_parser.sv
// -----------------------------------------------------------------------------
// sb_transaction_parser
//
// Parses the de-serialised sideband symbol stream (one byte per sbrx_vld
// strobe) into AT command/response transactions and LT transactions.
// DLE stuffing is removed and AT data bytes are buffered, up to MAX_BYTES.
// A completed AT is held on a valid/ready output register. A received LT is
// reported as a one-cycle event.
//
// Optional feature macro: SB_TIMEOUT_EN
//   defined   : a mid-frame idle counter aborts the frame after TIMEOUT_CYC
//               cycles without a symbol (trans_error pulse, back to IDLE).
//   undefined : no counter; the parser waits indefinitely.
//
// Ports
//   sb_clk       SB clock, all logic on rising edge
//   rst          synchronous reset, active-high
//   sbrx_vld     sbrx_sym carries a symbol this cycle
//   sbrx_sym     received symbol
//   crc_error    CRC verdict, sampled with the ETX symbol
//   tconnect     link connected (level)
//   tdisconnect  link disconnect request (level, highest priority)
//   crc_det_en   high on de-stuffed symbols STX..last CRC byte
//   t_valid      completed AT held on t_* outputs
//   t_ready      consumer accepts the held AT
//   t_is_resp    1 = response frame, 0 = command frame
//   t_write      write command (0 for responses)
//   t_read       read command (0 for responses)
//   t_address    header address byte
//   t_len        declared data byte count
//   t_payload    data, byte i at [8i+7:8i], unused bytes 0
//   lt_valid     one-cycle pulse: valid LT received
//   lt_lse       LSE[6:0] of the last valid LT
//   trans_error  one-cycle pulse: frame aborted
//   overflow     one-cycle pulse: completed AT dropped, output register busy
//   disconnect   high while in DISCONNECT
// -----------------------------------------------------------------------------
module sb_transaction_parser #(
    parameter int MAX_BYTES   = 8,
    parameter int LEN_W       = 7,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                   sb_clk,
    input  logic                   rst,
    input  logic                   sbrx_vld,
    input  logic [7:0]             sbrx_sym,
    input  logic                   crc_error,
    input  logic                   tconnect,
    input  logic                   tdisconnect,
    output logic                   crc_det_en,
    output logic                   t_valid,
    input  logic                   t_ready,
    output logic                   t_is_resp,
    output logic                   t_write,
    output logic                   t_read,
    output logic [7:0]             t_address,
    output logic [LEN_W-1:0]       t_len,
    output logic [MAX_BYTES*8-1:0] t_payload,
    output logic                   lt_valid,
    output logic [6:0]             lt_lse,
    output logic                   trans_error,
    output logic                   overflow,
    output logic                   disconnect
);

    localparam int CNT_W = LEN_W + 1;
    localparam int PL_W  = MAX_BYTES * 8;

    localparam logic [7:0] SYM_DLE     = 8'hFE;
    localparam logic [7:0] SYM_STX_CMD = 8'h05;
    localparam logic [7:0] SYM_STX_RSP = 8'h04;
    localparam logic [7:0] SYM_ETX     = 8'h40;

    typedef enum logic [3:0] {
        S_DISC,
        S_IDLE,
        S_DLE1,
        S_LT,
        S_HDR_A,
        S_HDR_L,
        S_DATA,
        S_CRC0,
        S_CRC1,
        S_ETX
    } state_t;

    // Parser state
    state_t           state_q, state_d;
    logic             esc_q, esc_d;      // first DLE of a stuffed pair seen
    logic [CNT_W-1:0] cnt_q, cnt_d;      // data bytes received, saturating
    logic [LEN_W-1:0] len_q, len_d;
    logic [7:0]       addr_q, addr_d;
    logic             rw_q, rw_d;
    logic             resp_q, resp_d;
    logic [7:0]       lse_q, lse_d;
    logic [PL_W-1:0]  buf_q, buf_d;

    // Output register
    logic             t_valid_q;
    logic             t_is_resp_q;
    logic             t_write_q;
    logic             t_read_q;
    logic [7:0]       t_address_q;
    logic [LEN_W-1:0] t_len_q;
    logic [PL_W-1:0]  t_payload_q;
    logic             lt_valid_q;
    logic [6:0]       lt_lse_q;
    logic             trans_error_q;
    logic             overflow_q;

    // Per-cycle events from the parser
    logic             commit;
    logic             lt_hit;
    logic             err_pulse;
    logic             crc_en;
    logic             tmo_hit;
    logic [CNT_W-1:0] cnt_inc;

`ifdef SB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Counts idle cycles while a frame is in progress; any symbol restarts it.
    always_comb begin
        tmo_d   = '0;
        tmo_hit = 1'b0;
        if (!sbrx_vld && state_q != S_DISC && state_q != S_IDLE) begin
            if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                tmo_hit = 1'b1;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
    end

    always_ff @(posedge sb_clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        esc_d     = esc_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        resp_d    = resp_q;
        lse_d     = lse_q;
        buf_d     = buf_q;
        commit    = 1'b0;
        lt_hit    = 1'b0;
        err_pulse = 1'b0;
        crc_en    = 1'b0;

        if (state_q == S_DISC) begin
            if (tconnect && !tdisconnect) begin
                state_d = S_IDLE;
            end
        end else if (tdisconnect) begin
            // In-flight frame is silently dropped.
            state_d = S_DISC;
            esc_d   = 1'b0;
        end else if (tmo_hit) begin
            state_d   = S_IDLE;
            esc_d     = 1'b0;
            err_pulse = 1'b1;
        end else if (sbrx_vld) begin
            case (state_q)
                S_IDLE: begin
                    if (sbrx_sym == SYM_DLE) begin
                        state_d = S_DLE1;
                    end
                end
                S_DLE1: begin
                    if (sbrx_sym == SYM_STX_CMD || sbrx_sym == SYM_STX_RSP) begin
                        resp_d  = (sbrx_sym == SYM_STX_RSP);
                        cnt_d   = '0;
                        buf_d   = '0;
                        esc_d   = 1'b0;
                        crc_en  = 1'b1;
                        state_d = S_HDR_A;
                    end else if (sbrx_sym == SYM_DLE) begin
                        // DLE is checked before LSE because 8'hFE has bit7 set.
                        state_d = S_DLE1;
                    end else if (sbrx_sym[7]) begin
                        lse_d   = sbrx_sym;
                        state_d = S_LT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_LT: begin
                    if (sbrx_sym == ~lse_q) begin
                        lt_hit = 1'b1;
                    end else begin
                        err_pulse = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                S_ETX: begin
                    if (!esc_q) begin
                        if (sbrx_sym == SYM_DLE) begin
                            esc_d = 1'b1;
                        end else begin
                            err_pulse = 1'b1;
                            state_d   = S_IDLE;
                        end
                    end else begin
                        esc_d   = 1'b0;
                        state_d = S_IDLE;
                        if (sbrx_sym == SYM_ETX && !crc_error) begin
                            commit = 1'b1;
                        end else begin
                            err_pulse = 1'b1;
                        end
                    end
                end
                S_HDR_A, S_HDR_L, S_DATA, S_CRC0, S_CRC1: begin
                    if (!esc_q && sbrx_sym == SYM_DLE) begin
                        esc_d = 1'b1;
                    end else if (esc_q && sbrx_sym != SYM_DLE) begin
                        esc_d     = 1'b0;
                        err_pulse = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        // A de-stuffed byte: either a plain byte or DLE DLE -> 8'hFE.
                        esc_d  = 1'b0;
                        crc_en = 1'b1;
                        case (state_q)
                            S_HDR_A: begin
                                addr_d  = sbrx_sym;
                                state_d = S_HDR_L;
                            end
                            S_HDR_L: begin
                                rw_d  = sbrx_sym[7];
                                len_d = sbrx_sym[LEN_W-1:0];
                                if ({1'b0, sbrx_sym[LEN_W-1:0]} > CNT_W'(MAX_BYTES)) begin
                                    err_pulse = 1'b1;
                                    state_d   = S_IDLE;
                                end else if (sbrx_sym[LEN_W-1:0] == '0) begin
                                    state_d = S_CRC0;
                                end else begin
                                    state_d = S_DATA;
                                end
                            end
                            S_DATA: begin
                                for (int i = 0; i < MAX_BYTES; i++) begin
                                    if (cnt_q == CNT_W'(i)) begin
                                        buf_d[i*8 +: 8] = sbrx_sym;
                                    end
                                end
                                cnt_d = cnt_inc;
                                if (cnt_inc == {1'b0, len_q}) begin
                                    state_d = S_CRC0;
                                end
                            end
                            S_CRC0:  state_d = S_CRC1;
                            default: state_d = S_ETX;
                        endcase
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge sb_clk) begin
        if (rst) begin
            state_q <= S_DISC;
            esc_q   <= 1'b0;
            cnt_q   <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            resp_q  <= 1'b0;
            lse_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            esc_q   <= esc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            resp_q  <= resp_d;
            lse_q   <= lse_d;
            buf_q   <= buf_d;
        end
    end

    // Output register: independent of parser state, only rst clears it.
    always_ff @(posedge sb_clk) begin
        if (rst) begin
            t_valid_q     <= 1'b0;
            t_is_resp_q   <= 1'b0;
            t_write_q     <= 1'b0;
            t_read_q      <= 1'b0;
            t_address_q   <= '0;
            t_len_q       <= '0;
            t_payload_q   <= '0;
            lt_valid_q    <= 1'b0;
            lt_lse_q      <= '0;
            trans_error_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            trans_error_q <= err_pulse;
            lt_valid_q    <= lt_hit;
            overflow_q    <= 1'b0;
            if (lt_hit) begin
                lt_lse_q <= lse_q[6:0];
            end
            if (commit) begin
                if (t_valid_q && !t_ready) begin
                    overflow_q <= 1'b1;
                end else begin
                    // Either empty, or the held AT is accepted on this same edge.
                    t_valid_q   <= 1'b1;
                    t_is_resp_q <= resp_q;
                    t_write_q   <= !resp_q && rw_q;
                    t_read_q    <= !resp_q && !rw_q;
                    t_address_q <= addr_q;
                    t_len_q     <= len_q;
                    t_payload_q <= buf_q;
                end
            end else if (t_valid_q && t_ready) begin
                t_valid_q <= 1'b0;
            end
        end
    end

    assign crc_det_en  = crc_en;
    assign t_valid     = t_valid_q;
    assign t_is_resp   = t_is_resp_q;
    assign t_write     = t_write_q;
    assign t_read      = t_read_q;
    assign t_address   = t_address_q;
    assign t_len       = t_len_q;
    assign t_payload   = t_payload_q;
    assign lt_valid    = lt_valid_q;
    assign lt_lse      = lt_lse_q;
    assign trans_error = trans_error_q;
    assign overflow    = overflow_q;
    assign disconnect  = (state_q == S_DISC);

endmodule

// File: tb/tb_sb_transaction_parser.sv
// -----------------------------------------------------------------------------
// tb_sb_transaction_parser
//
// Directed bench for sb_transaction_parser with MAX_BYTES=8, LEN_W=7 and
// TIMEOUT_CYC=16. Symbols are driven one per clock; outputs are sampled 1 ns
// after the rising edge. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_sb_transaction_parser;

    localparam int MAX_BYTES = 8;
    localparam int LEN_W     = 7;

    logic                   clk;
    logic                   rst;
    logic                   sbrx_vld;
    logic [7:0]             sbrx_sym;
    logic                   crc_error;
    logic                   tconnect;
    logic                   tdisconnect;
    logic                   crc_det_en;
    logic                   t_valid;
    logic                   t_ready;
    logic                   t_is_resp;
    logic                   t_write;
    logic                   t_read;
    logic [7:0]             t_address;
    logic [LEN_W-1:0]       t_len;
    logic [MAX_BYTES*8-1:0] t_payload;
    logic                   lt_valid;
    logic [6:0]             lt_lse;
    logic                   trans_error;
    logic                   overflow;
    logic                   disconnect;

    int checks;
    int errors;

    logic [7:0] frm[$];

    sb_transaction_parser #(
        .MAX_BYTES   (MAX_BYTES),
        .LEN_W       (LEN_W),
        .TIMEOUT_CYC (16)
    ) dut (
        .sb_clk      (clk),
        .rst         (rst),
        .sbrx_vld    (sbrx_vld),
        .sbrx_sym    (sbrx_sym),
        .crc_error   (crc_error),
        .tconnect    (tconnect),
        .tdisconnect (tdisconnect),
        .crc_det_en  (crc_det_en),
        .t_valid     (t_valid),
        .t_ready     (t_ready),
        .t_is_resp   (t_is_resp),
        .t_write     (t_write),
        .t_read      (t_read),
        .t_address   (t_address),
        .t_len       (t_len),
        .t_payload   (t_payload),
        .lt_valid    (lt_valid),
        .lt_lse      (lt_lse),
        .trans_error (trans_error),
        .overflow    (overflow),
        .disconnect  (disconnect)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] s);
        sbrx_vld = 1'b1;
        sbrx_sym = s;
        tick();
        sbrx_vld = 1'b0;
    endtask

    task automatic send_frm();
        foreach (frm[i]) send(frm[i]);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        sbrx_vld    = 1'b0;
        sbrx_sym    = 8'h00;
        crc_error   = 1'b0;
        tconnect    = 1'b0;
        tdisconnect = 1'b0;
        t_ready     = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        chk("rst_disconnect", 64'(disconnect), 64'd1);
        chk("rst_t_valid", 64'(t_valid), 64'd0);
        chk("rst_payload", 64'(t_payload), 64'd0);
        chk("rst_trans_error", 64'(trans_error), 64'd0);
        chk("rst_lt_valid", 64'(lt_valid), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_crc_det_en", 64'(crc_det_en), 64'd0);

        tconnect = 1'b1;
        tick();
        tconnect = 1'b0;
        chk("connect", 64'(disconnect), 64'd0);

        // Write command with a stuffed FE data byte
        send(8'hFE);
        send(8'h05);
        sbrx_vld = 1'b1;
        sbrx_sym = 8'h12;
        #1;
        chk("crc_det_en_hdr", 64'(crc_det_en), 64'd1);
        tick();
        sbrx_vld = 1'b0;
        frm = '{8'h83, 8'hAA, 8'hFE, 8'hFE, 8'hCC, 8'h11, 8'h22, 8'hFE};
        send_frm();
        chk("wr_not_early", 64'(t_valid), 64'd0);
        send(8'h40);
        chk("wr_t_valid", 64'(t_valid), 64'd1);
        chk("wr_t_write", 64'(t_write), 64'd1);
        chk("wr_t_read", 64'(t_read), 64'd0);
        chk("wr_t_is_resp", 64'(t_is_resp), 64'd0);
        chk("wr_t_address", 64'(t_address), 64'h12);
        chk("wr_t_len", 64'(t_len), 64'd3);
        chk("wr_t_payload", t_payload, 64'h0000_0000_00CC_FEAA);

        // Second frame while the first is held -> overflow
        frm = '{8'hFE, 8'h05, 8'h34, 8'h01, 8'h55, 8'h11, 8'h22, 8'hFE, 8'h40};
        send_frm();
        chk("ovf_pulse", 64'(overflow), 64'd1);
        chk("ovf_addr_held", 64'(t_address), 64'h12);
        chk("ovf_t_valid", 64'(t_valid), 64'd1);
        tick();
        chk("ovf_pulse_end", 64'(overflow), 64'd0);

        t_ready = 1'b1;
        tick();
        t_ready = 1'b0;
        chk("hs_t_valid_clr", 64'(t_valid), 64'd0);

        // Valid LT
        frm = '{8'hFE, 8'h85, 8'h7A};
        send_frm();
        chk("lt_valid", 64'(lt_valid), 64'd1);
        chk("lt_lse", 64'(lt_lse), 64'h05);
        chk("lt_no_err", 64'(trans_error), 64'd0);
        tick();
        chk("lt_pulse_end", 64'(lt_valid), 64'd0);

        // Bad LT complement
        frm = '{8'hFE, 8'h85, 8'h7B};
        send_frm();
        chk("lt_bad_err", 64'(trans_error), 64'd1);
        chk("lt_bad_no_valid", 64'(lt_valid), 64'd0);

        // Read, len 0, CRC error
        frm = '{8'hFE, 8'h05, 8'h20, 8'h00, 8'h11, 8'h22, 8'hFE};
        send_frm();
        crc_error = 1'b1;
        send(8'h40);
        crc_error = 1'b0;
        chk("crc_err_pulse", 64'(trans_error), 64'd1);
        chk("crc_err_no_valid", 64'(t_valid), 64'd0);

        // Length 9 exceeds MAX_BYTES
        frm = '{8'hFE, 8'h05, 8'h20, 8'h09};
        send_frm();
        chk("len9_err", 64'(trans_error), 64'd1);
        send(8'h01);
        send(8'h02);
        chk("len9_err_end", 64'(trans_error), 64'd0);

        // Disconnect mid-DATA
        frm = '{8'hFE, 8'h05, 8'h12, 8'h82, 8'hAA};
        send_frm();
        tdisconnect = 1'b1;
        tick();
        tdisconnect = 1'b0;
        chk("disc_high", 64'(disconnect), 64'd1);
        chk("disc_no_err", 64'(trans_error), 64'd0);
        tconnect = 1'b1;
        tick();
        tconnect = 1'b0;
        chk("reconnect", 64'(disconnect), 64'd0);

        // Response frame
        frm = '{8'hFE, 8'h04, 8'h56, 8'h82, 8'h01, 8'h02, 8'h11, 8'h22, 8'hFE, 8'h40};
        send_frm();
        chk("rsp_t_valid", 64'(t_valid), 64'd1);
        chk("rsp_is_resp", 64'(t_is_resp), 64'd1);
        chk("rsp_t_write", 64'(t_write), 64'd0);
        chk("rsp_t_read", 64'(t_read), 64'd0);
        chk("rsp_t_address", 64'(t_address), 64'h56);
        chk("rsp_t_len", 64'(t_len), 64'd2);
        chk("rsp_payload", t_payload, 64'h0000_0000_0000_0201);

        // Max-length frame committed on the same edge the held AT is accepted
        frm = '{8'hFE, 8'h05, 8'h77, 8'h88, 8'h01, 8'h02, 8'h03, 8'h04,
                8'h05, 8'h06, 8'h07, 8'h08, 8'h11, 8'h22, 8'hFE};
        send_frm();
        t_ready = 1'b1;
        send(8'h40);
        chk("max_t_valid", 64'(t_valid), 64'd1);
        chk("max_no_ovf", 64'(overflow), 64'd0);
        chk("max_t_address", 64'(t_address), 64'h77);
        chk("max_t_len", 64'(t_len), 64'd8);
        chk("max_payload", t_payload, 64'h0807_0605_0403_0201);
        tick();
        t_ready = 1'b0;
        chk("max_hs_clr", 64'(t_valid), 64'd0);

`ifdef SB_TIMEOUT_EN
        // Mid-frame timeout
        frm = '{8'hFE, 8'h05, 8'h12};
        send_frm();
        repeat (15) tick();
        chk("tmo_not_early", 64'(trans_error), 64'd0);
        tick();
        chk("tmo_pulse", 64'(trans_error), 64'd1);
        frm = '{8'hFE, 8'h05, 8'h44, 8'h81, 8'h5A, 8'h11, 8'h22, 8'hFE, 8'h40};
        send_frm();
        chk("tmo_next_valid", 64'(t_valid), 64'd1);
        chk("tmo_next_addr", 64'(t_address), 64'h44);
        chk("tmo_next_payload", t_payload, 64'h0000_0000_0000_005A);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
